line_buf_mem_bridge: RTL and testbench

- Sits directly downstream of the multicycle RV32I control/datapath memory port.
- Accepts single-word CPU requests (mem_read/mem_write, hold-until-mem_resp) and serves them from a one-line buffer.
- Talks to physical memory through a BURST_BEATS-beat burst interface: line fills on miss, full-line write-through on every store.

---
 rtl/line_buf_mem_bridge.sv | 144 ++++++++++++++
 tb/tb_line_buf_mem_bridge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/line_buf_mem_bridge.sv
// One-line buffer between the CPU word port and a burst-oriented physical memory.
// Optional hit/miss counters are built when LINE_BUF_STATS_EN is defined.
module line_buf_mem_bridge #(
  parameter int unsigned BEAT_W      = 64,
  parameter int unsigned BURST_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef LINE_BUF_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned LINE_W = BEAT_W * BURST_BEATS;
  localparam int unsigned OFS    = $clog2(LINE_W / 8);
  localparam int unsigned KW     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int unsigned TAG_W  = 32 - OFS;

  typedef enum logic [2:0] {IDLE, FILL, MERGE, WB, RESP} state_t;

  state_t              state, state_nxt;
  logic [LINE_W-1:0]   line;
  logic                valid;
  logic [TAG_W-1:0]    tag;
  logic [KW-1:0]       k;
  logic                req_wr;
  logic [31:0]         req_addr;
  logic                hit;
  logic                last_beat;
  logic [OFS-3:0]      req_word;

  assign hit       = valid && (tag == mem_address[31:OFS]);
  assign last_beat = (k == KW'(BURST_BEATS - 1));
  assign req_word  = req_addr[OFS-1:2];

  always_comb begin
    state_nxt    = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (mem_write)     state_nxt = hit ? MERGE : FILL;
        else if (mem_read) state_nxt = hit ? RESP : FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_addr[31:OFS], {OFS{1'b0}}};
        if (pmem_resp && last_beat) state_nxt = req_wr ? MERGE : RESP;
      end
      MERGE: state_nxt = WB;
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {req_addr[31:OFS], {OFS{1'b0}}};
        pmem_wdata   = line[int'(k)*BEAT_W +: BEAT_W];
        if (pmem_resp && last_beat) state_nxt = RESP;
      end
      RESP: begin
        mem_resp  = 1'b1;
        mem_rdata = line[int'(req_word)*32 +: 32];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      line     <= '0;
      valid    <= 1'b0;
      tag      <= '0;
      k        <= '0;
      req_wr   <= 1'b0;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            req_wr   <= mem_write;
            req_addr <= mem_address;
            // line is overwritten beat by beat, so it stops matching any tag until the fill completes
            if (!hit) valid <= 1'b0;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            line[int'(k)*BEAT_W +: BEAT_W] <= pmem_rdata;
            k <= last_beat ? '0 : k + 1'b1;
            if (last_beat) begin
              valid <= 1'b1;
              tag   <= req_addr[31:OFS];
            end
          end
        end
        MERGE: begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (mem_byte_enable[b])
              line[int'(req_word)*32 + int'(b)*8 +: 8] <= mem_wdata[b*8 +: 8];
          end
        end
        WB: begin
          if (pmem_resp) k <= last_beat ? '0 : k + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_BUF_STATS_EN
  logic accept;
  assign accept = (state == IDLE) && (mem_read || mem_write);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit && (hit_count != '1))         hit_count  <= hit_count + 32'd1;
      else if (!hit && (miss_count != '1))  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_buf_mem_bridge.sv
// Directed bench for line_buf_mem_bridge: misses, hits, write-through, reset mid-fill.
module tb_line_buf_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_address = '0, mem_wdata = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
`ifdef LINE_BUF_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  line_buf_mem_bridge #(.BEAT_W(64), .BURST_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef LINE_BUF_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] rd_beats[4];
  logic [63:0] wb_got[4];
  int          rd_n, wb_n, wait_n, addr_err;
  logic [31:0] rdata_got;
  bit          done, aborted;

  // Drives one CPU request and plays the memory side; abort_at>0 asserts reset after that many fill beats.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_line, input int abort_at);
    rd_n = 0; wb_n = 0; wait_n = 0; addr_err = 0; rdata_got = '0; done = 0; aborted = 0;
    for (int i = 0; i < 4; i++) wb_got[i] = '0;
    @(posedge clk); #1;
    mem_read = !wr; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp) begin
        rdata_got = mem_rdata;
        done = 1;
      end else begin
        wait_n++;
        if (pmem_read) begin
          if (pmem_address !== exp_line) addr_err++;
          if (abort_at != 0 && rd_n == abort_at) begin
            rst = 1'b0;
            #1;
            check("abort_pmem_read", {63'd0, pmem_read}, 64'd0);
            check("abort_pmem_addr", {32'd0, pmem_address}, 64'd0);
            aborted = 1;
            done = 1;
          end else begin
            pmem_rdata = rd_beats[rd_n % 4];
            pmem_resp  = 1'b1;
            rd_n++;
          end
        end else if (pmem_write) begin
          if (pmem_address !== exp_line) addr_err++;
          wb_got[wb_n % 4] = pmem_wdata;
          pmem_resp = 1'b1;
          wb_n++;
        end
      end
    end
    check("req_done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    if (!aborted) begin
      @(negedge clk);
      check("resp_single_cycle", {63'd0, mem_resp}, 64'd0);
      check("rdata_idle_zero", {32'd0, mem_rdata}, 64'd0);
    end
  endtask

  initial begin
    @(negedge clk);
    check("rst_outputs", {mem_resp, pmem_read, pmem_write}, 64'd0);
    check("rst_rdata", {32'd0, mem_rdata}, 64'd0);
    check("rst_paddr", {32'd0, pmem_address}, 64'd0);
    check("rst_pwdata", pmem_wdata, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // cold read miss
    rd_beats[0] = 64'h1111_1111_0000_0000; rd_beats[1] = 64'h3333_3333_2222_2222;
    rd_beats[2] = 64'h5555_5555_4444_4444; rd_beats[3] = 64'h7777_7777_6666_6666;
    do_req(0, 32'h0000_0044, '0, '0, 32'h0000_0040, 0);
    check("miss_rd_beats", rd_n, 4);
    check("miss_wb_beats", wb_n, 0);
    check("miss_addr", addr_err, 0);
    check("miss_wait", wait_n, 5);
    check("miss_rdata", {32'd0, rdata_got}, 64'h1111_1111);

    // read hit: word 6 of the line
    do_req(0, 32'h0000_0058, '0, '0, 32'h0000_0040, 0);
    check("hit_rd_beats", rd_n, 0);
    check("hit_wb_beats", wb_n, 0);
    check("hit_wait", wait_n, 1);
    check("hit_rdata", {32'd0, rdata_got}, 64'h6666_6666);

    // write hit, partial byte mask
    do_req(1, 32'h0000_0044, 32'hAABB_CCDD, 4'b0101, 32'h0000_0040, 0);
    check("wh_rd_beats", rd_n, 0);
    check("wh_wb_beats", wb_n, 4);
    check("wh_addr", addr_err, 0);
    check("wh_beat0", wb_got[0], 64'h11BB_11DD_0000_0000);
    check("wh_beat3", wb_got[3], 64'h7777_7777_6666_6666);
    check("wh_wait", wait_n, 6);
    check("wh_rdata", {32'd0, rdata_got}, 64'h11BB_11DD);

    // write miss, full mask
    rd_beats[0] = 64'hC0C0_C0C0_0BAD_F00D; rd_beats[1] = 64'hC1C1_C1C1_C1C1_C1C1;
    rd_beats[2] = 64'hC2C2_C2C2_C2C2_C2C2; rd_beats[3] = 64'hC3C3_C3C3_C3C3_C3C3;
    do_req(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0000_1000, 0);
    check("wm_rd_beats", rd_n, 4);
    check("wm_wb_beats", wb_n, 4);
    check("wm_addr", addr_err, 0);
    check("wm_beat0", wb_got[0], 64'hC0C0_C0C0_DEAD_BEEF);
    check("wm_beat1", wb_got[1], 64'hC1C1_C1C1_C1C1_C1C1);
    check("wm_wait", wait_n, 10);
    check("wm_rdata", {32'd0, rdata_got}, 64'hDEAD_BEEF);
`ifdef LINE_BUF_STATS_EN
    check("stats_hit_pre", {32'd0, hit_count}, 64'd2);
    check("stats_miss_pre", {32'd0, miss_count}, 64'd2);
`endif

    // reset after two fill beats of a miss to line 0x40
    rd_beats[0] = 64'hD0D0_D0D0_D0D0_D0D0; rd_beats[1] = 64'hD1D1_D1D1_D1D1_D1D1;
    rd_beats[2] = 64'hD2D2_D2D2_D2D2_D2D2; rd_beats[3] = 64'hD3D3_D3D3_D3D3_D3D3;
    do_req(0, 32'h0000_0044, '0, '0, 32'h0000_0040, 2);
    check("abort_seen", {63'd0, aborted}, 64'd1);
    check("abort_beats", rd_n, 2);
    @(negedge clk);
    check("inrst_outputs", {mem_resp, pmem_read, pmem_write}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    rd_beats[0] = 64'hE0E0_E0E0_1234_5678; rd_beats[1] = 64'hE1E1_E1E1_E1E1_E1E1;
    rd_beats[2] = 64'hE2E2_E2E2_E2E2_E2E2; rd_beats[3] = 64'hE3E3_E3E3_E3E3_E3E3;
    do_req(0, 32'h0000_1000, '0, '0, 32'h0000_1000, 0);
    check("post_rst_rd_beats", rd_n, 4);
    check("post_rst_addr", addr_err, 0);
    check("post_rst_wait", wait_n, 5);
    check("post_rst_rdata", {32'd0, rdata_got}, 64'h1234_5678);
`ifdef LINE_BUF_STATS_EN
    check("stats_hit_post", {32'd0, hit_count}, 64'd0);
    check("stats_miss_post", {32'd0, miss_count}, 64'd1);
`endif

    // zero byte mask: full write-through of unchanged data
    do_req(1, 32'h0000_1000, 32'hFFFF_FFFF, 4'h0, 32'h0000_1000, 0);
    check("be0_rd_beats", rd_n, 0);
    check("be0_wb_beats", wb_n, 4);
    check("be0_beat0", wb_got[0], 64'hE0E0_E0E0_1234_5678);
    check("be0_beat2", wb_got[2], 64'hE2E2_E2E2_E2E2_E2E2);
    check("be0_rdata", {32'd0, rdata_got}, 64'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
